// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Memory end of the CPU data-memory request/response handshake. One load or
// store is accepted at a time. After WAIT_STATES stall cycles it is served
// from a word-organised SRAM. RV32I byte/half/word sizing is selected by
// funct3, and loads are sign- or zero-extended. Misaligned, out-of-range and
// illegal-funct3 accesses are answered with an error response and leave the
// array untouched.
//
// Ports
//   i_clock       clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_req_valid   request valid
//   o_req_ready   responder idle, request accepted on this edge if valid
//   i_req_we      1 = store, 0 = load
//   i_req_addr    byte address
//   i_req_wdata   store data, right-aligned
//   i_req_funct3  RV32I load/store funct3
//   o_rsp_valid   response valid (held until i_rsp_ready)
//   i_rsp_ready   requester accepts the response
//   o_rsp_rdata   extended load data, 0 for stores and errors
//   o_rsp_err     access rejected
// ----------------------------------------------------------------------------
module dmem_responder #(
   parameter int NB_WORD     = 32,
   parameter int NB_ADDR     = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_we,
   input  logic [NB_ADDR-1:0] i_req_addr,
   input  logic [NB_WORD-1:0] i_req_wdata,
   input  logic [2:0]         i_req_funct3,
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic [NB_WORD-1:0] o_rsp_rdata,
   output logic               o_rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t             state;
   logic [3:0]         wait_cnt;
   logic               lat_we;
   logic [AW+1:0]      lat_addr;
   logic [NB_WORD-1:0] lat_wdata;
   logic [2:0]         lat_f3;
   logic [NB_WORD-1:0] mem [DEPTH_WORDS];
   logic [NB_WORD-1:0] rd_word;
   logic [AW-1:0]      word_idx;

   // Legality is decided from the live request at the accepting edge so an
   // illegal access can be answered one edge later.
   function automatic logic req_illegal(input logic               we,
                                        input logic [2:0]         f3,
                                        input logic [NB_ADDR-1:0] addr);
      logic bad_f3;
      logic misal;
      logic oor;
      if (we)
         bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
      else
         bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misal = ((f3[1:0] == 2'b01) && addr[0]) ||
              ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      oor   = {2'b00, addr[NB_ADDR-1:2]} >= NB_ADDR'(DEPTH_WORDS);
      return bad_f3 | misal | oor;
   endfunction

   // Little-endian lane select followed by sign/zero extension.
   function automatic logic [NB_WORD-1:0] load_extract(input logic [NB_WORD-1:0] word,
                                                       input logic [2:0]         f3,
                                                       input logic [1:0]         off);
      logic        [7:0]         b;
      logic        [15:0]        h;
      logic signed [NB_WORD-1:0] ext;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  ext = $signed(b);
         3'b001:  ext = $signed(h);
         3'b100:  ext = $signed({{(NB_WORD-8){1'b0}}, b});
         3'b101:  ext = $signed({{(NB_WORD-16){1'b0}}, h});
         default: ext = $signed(word);
      endcase
      return $unsigned(ext);
   endfunction

   // Replace only the addressed lanes; all other bytes keep their old value.
   function automatic logic [NB_WORD-1:0] store_merge(input logic [NB_WORD-1:0] old,
                                                      input logic [NB_WORD-1:0] wdata,
                                                      input logic [2:0]         f3,
                                                      input logic [1:0]         off);
      logic [NB_WORD-1:0] r;
      r = old;
      case (f3)
         3'b000:  r[{off, 3'b000} +: 8]     = wdata[7:0];
         3'b001:  r[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: r = wdata;
      endcase
      return r;
   endfunction

   assign word_idx = lat_addr[AW+1:2];
   assign rd_word  = mem[word_idx];

   // Request capture: data only, no reset needed.
   always_ff @(posedge i_clock) begin
      if (state == S_IDLE && i_req_valid) begin
         lat_we    <= i_req_we;
         lat_addr  <= i_req_addr[AW+1:0];
         lat_wdata <= i_req_wdata;
         lat_f3    <= i_req_funct3;
      end
   end

   // SRAM write at the ACCESS exit edge. A reset before this edge has already
   // forced the FSM out of ACCESS, so an aborted store never lands.
   always_ff @(posedge i_clock) begin
      if (state == S_ACCESS && lat_we)
         mem[word_idx] <= store_merge(rd_word, lat_wdata, lat_f3, lat_addr[1:0]);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         o_req_ready <= 1'b1;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_req_valid) begin
                  o_req_ready <= 1'b0;
                  if (req_illegal(i_req_we, i_req_funct3, i_req_addr)) begin
                     state       <= S_RESP;
                     o_rsp_valid <= 1'b1;
                     o_rsp_err   <= 1'b1;
                     o_rsp_rdata <= '0;
                  end else if (WAIT_STATES == 0) begin
                     state <= S_ACCESS;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= WAIT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0)
                  state <= S_ACCESS;
               else
                  wait_cnt <= wait_cnt - 4'd1;
            end
            S_ACCESS: begin
               state       <= S_RESP;
               o_rsp_valid <= 1'b1;
               o_rsp_err   <= 1'b0;
               o_rsp_rdata <= lat_we ? '0 : load_extract(rd_word, lat_f3, lat_addr[1:0]);
            end
            S_RESP: begin
               if (i_rsp_ready) begin
                  state       <= S_IDLE;
                  o_req_ready <= 1'b1;
                  o_rsp_valid <= 1'b0;
                  o_rsp_err   <= 1'b0;
                  o_rsp_rdata <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share one clock: index 1 has one wait state, index 0 has
// none. Expected responses (data, error flag, latency in edges counted from
// the accepting edge) are queued when a request is driven and popped when the
// response appears.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int WS1   = 1;
   localparam int WS0   = 0;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;
   localparam logic [2:0] F_X  = 3'b011;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [2:0]  f3;
      logic [31:0] rd;
      logic        err;
      string       name;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [2:0]  req_f3    [2];
   logic [31:0] rsp_rdata [2];

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(.NB_WORD(32), .NB_ADDR(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
      .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_funct3(req_f3[1]),
      .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
      .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
   );

   dmem_responder #(.NB_WORD(32), .NB_ADDR(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut_nw (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
      .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_funct3(req_f3[0]),
      .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
      .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
   );

   task automatic set_req(input int sel, input logic v, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
      req_valid[sel] = v;
      req_we[sel]    = we;
      req_addr[sel]  = addr;
      req_wdata[sel] = wd;
      req_f3[sel]    = f3;
   endtask

   function automatic void push_exp(input req_t r, input int ws);
      exp_t e;
      e.rdata = r.rd;
      e.err   = r.err;
      e.lat   = r.err ? 1 : ws + 2;
      e.name  = r.name;
      sb.push_back(e);
   endfunction

   // Drives one request from a negedge, waits for the response and lets it
   // handshake. lat = negedges after the accepting edge until valid is seen
   // (the accepting edge counts as 1); -1 on timeout, -2 if never accepted.
   task automatic run_txn(input int sel, input req_t r,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rdy_after);
      bit acc;
      acc = 0;
      rsp_ready[sel] = 1'b1;
      set_req(sel, 1'b1, r.we, r.addr, r.wd, r.f3);
      for (int i = 0; i < 20 && !acc; i++) begin
         if (req_ready[sel]) acc = 1;
         @(posedge clk);
      end
      #1 req_valid[sel] = 1'b0;
      lat = acc ? -1 : -2;
      rd  = 'x;
      er  = 1'bx;
      if (acc) begin
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid[sel]) begin
               lat = i;
               break;
            end
         end
      end
      rd = rsp_rdata[sel];
      er = rsp_err[sel];
      @(negedge clk);
      rdy_after = req_ready[sel];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         set_req(s, 1'b0, 1'b0, 32'h0, 32'h0, F_W);
         rsp_ready[s] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         checks++; if (req_ready[s] !== 1'b1) begin failures++; $display("FAIL reset_req_ready[%0d] got=%b exp=1", s, req_ready[s]); end
         checks++; if (rsp_valid[s] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid[%0d] got=%b exp=0", s, rsp_valid[s]); end
         checks++; if (rsp_rdata[s] !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata[%0d] got=%h exp=0", s, rsp_rdata[s]); end
         checks++; if (rsp_err[s] !== 1'b0) begin failures++; $display("FAIL reset_rsp_err[%0d] got=%b exp=0", s, rsp_err[s]); end
      end
   endtask

   task automatic test_word_rw();
      req_t tbl[3];
      exp_t e;
      logic [31:0] rd; logic er, ra; int lat;
      tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, F_W, 32'h0,        1'b0, "sw_10"};
      tbl[1] = '{1'b0, 32'h10, 32'h0,        F_W, 32'hDEADBEEF, 1'b0, "lw_10"};
      tbl[2] = '{1'b1, 32'h20, 32'h0,        F_W, 32'h0,        1'b0, "sw_20_zero"};
      foreach (tbl[i]) begin
         push_exp(tbl[i], WS1);
         run_txn(1, tbl[i], rd, er, lat, ra);
         e = sb.pop_front();
         checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", e.name, rd, e.rdata); end
         checks++; if (er !== e.err) begin failures++; $display("FAIL %s err got=%b exp=%b", e.name, er, e.err); end
         checks++; if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat); end
      end
   endtask

   task automatic test_byte_lanes();
      req_t tbl[7];
      exp_t e;
      logic [31:0] rd; logic er, ra; int lat;
      tbl[0] = '{1'b1, 32'h11, 32'h00000080, F_B,  32'h0,        1'b0, "sb_11"};
      tbl[1] = '{1'b0, 32'h10, 32'h0,        F_W,  32'hDEAD80EF, 1'b0, "lw_after_sb"};
      tbl[2] = '{1'b0, 32'h11, 32'h0,        F_B,  32'hFFFFFF80, 1'b0, "lb_11"};
      tbl[3] = '{1'b0, 32'h11, 32'h0,        F_BU, 32'h00000080, 1'b0, "lbu_11"};
      tbl[4] = '{1'b0, 32'h12, 32'h0,        F_H,  32'hFFFFDEAD, 1'b0, "lh_12"};
      tbl[5] = '{1'b0, 32'h12, 32'h0,        F_HU, 32'h0000DEAD, 1'b0, "lhu_12"};
      tbl[6] = '{1'b0, 32'h10, 32'h0,        F_H,  32'hFFFF80EF, 1'b0, "lh_10"};
      foreach (tbl[i]) begin
         push_exp(tbl[i], WS1);
         run_txn(1, tbl[i], rd, er, lat, ra);
         e = sb.pop_front();
         checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", e.name, rd, e.rdata); end
         checks++; if (er !== e.err) begin failures++; $display("FAIL %s err got=%b exp=%b", e.name, er, e.err); end
         checks++; if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat); end
      end
   endtask

   task automatic test_errors();
      req_t tbl[9];
      exp_t e;
      logic [31:0] rd; logic er, ra; int lat;
      tbl[0] = '{1'b0, 32'h13,      32'h0,        F_H,    32'h0,        1'b1, "lh_13_misal"};
      tbl[1] = '{1'b0, 32'h13,      32'h0,        F_W,    32'h0,        1'b1, "lw_13_misal"};
      tbl[2] = '{1'b0, 32'h12,      32'h0,        F_W,    32'h0,        1'b1, "lw_12_misal"};
      tbl[3] = '{1'b0, 4 * DEPTH,   32'h0,        F_W,    32'h0,        1'b1, "lw_oor"};
      tbl[4] = '{1'b0, 32'h10,      32'h0,        F_X,    32'h0,        1'b1, "ld_f3_011"};
      tbl[5] = '{1'b1, 32'h10,      32'h11111111, F_BU,   32'h0,        1'b1, "st_f3_100"};
      tbl[6] = '{1'b1, 32'h11,      32'h2222,     F_H,    32'h0,        1'b1, "sh_11_misal"};
      tbl[7] = '{1'b1, 4 * DEPTH + 16, 32'h3,     F_W,    32'h0,        1'b1, "sw_oor"};
      tbl[8] = '{1'b0, 32'h10,      32'h0,        F_W,    32'hDEAD80EF, 1'b0, "lw_unchanged"};
      foreach (tbl[i]) begin
         push_exp(tbl[i], WS1);
         run_txn(1, tbl[i], rd, er, lat, ra);
         e = sb.pop_front();
         checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", e.name, rd, e.rdata); end
         checks++; if (er !== e.err) begin failures++; $display("FAIL %s err got=%b exp=%b", e.name, er, e.err); end
         checks++; if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat); end
      end
   endtask

   task automatic test_resp_hold();
      req_t r;
      exp_t e;
      logic [31:0] rd, rd0; logic er, ra; int lat;
      r = '{1'b0, 32'h10, 32'h0, F_W, 32'hDEAD80EF, 1'b0, "hold_lw"};
      push_exp(r, WS1);
      rsp_ready[1] = 1'b0;
      set_req(1, 1'b1, r.we, r.addr, r.wd, r.f3);
      @(posedge clk);
      // Second request (a store that would clobber the word) held valid meanwhile.
      #1 set_req(1, 1'b1, 1'b1, 32'h10, 32'h0, F_W);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (rsp_valid[1]) begin lat = i; break; end
      end
      e   = sb.pop_front();
      rd0 = rsp_rdata[1];
      checks++; if (rd0 !== e.rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", e.name, rd0, e.rdata); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (rsp_valid[1] !== 1'b1) begin failures++; $display("FAIL hold_valid c%0d got=%b exp=1", c, rsp_valid[1]); end
         checks++; if (rsp_rdata[1] !== e.rdata) begin failures++; $display("FAIL hold_rdata c%0d got=%h exp=%h", c, rsp_rdata[1], e.rdata); end
         checks++; if (rsp_err[1] !== 1'b0) begin failures++; $display("FAIL hold_err c%0d got=%b exp=0", c, rsp_err[1]); end
         checks++; if (req_ready[1] !== 1'b0) begin failures++; $display("FAIL hold_req_ready c%0d got=%b exp=0", c, req_ready[1]); end
      end
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", rsp_valid[1]); end
      checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", req_ready[1]); end
      r = '{1'b0, 32'h10, 32'h0, F_W, 32'hDEAD80EF, 1'b0, "hold_second_ignored"};
      push_exp(r, WS1);
      run_txn(1, r, rd, er, lat, ra);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", e.name, rd, e.rdata); end
   endtask

   task automatic test_reset_abort();
      req_t r;
      exp_t e;
      logic [31:0] rd; logic er, ra; int lat;
      set_req(1, 1'b1, 1'b1, 32'h20, 32'h12345678, F_W);
      checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL abort_accept_ready got=%b exp=1", req_ready[1]); end
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL abort_req_ready got=%b exp=1", req_ready[1]); end
      checks++; if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL abort_rsp_valid got=%b exp=0", rsp_valid[1]); end
      checks++; if (rsp_err[1] !== 1'b0) begin failures++; $display("FAIL abort_rsp_err got=%b exp=0", rsp_err[1]); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL abort_no_rsp got=%b exp=0", rsp_valid[1]); end
      r = '{1'b0, 32'h20, 32'h0, F_W, 32'h0, 1'b0, "abort_lw_20"};
      push_exp(r, WS1);
      run_txn(1, r, rd, er, lat, ra);
      e = sb.pop_front();
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", e.name, rd, e.rdata); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat); end
   endtask

   task automatic test_back_to_back();
      req_t tbl[5];
      exp_t e;
      logic [31:0] rd; logic er, ra; int lat;
      tbl[0] = '{1'b1, 32'h40, 32'hA5A50001, F_W,  32'h0,        1'b0, "b2b_sw_40"};
      tbl[1] = '{1'b0, 32'h40, 32'h0,        F_W,  32'hA5A50001, 1'b0, "b2b_lw_40"};
      tbl[2] = '{1'b0, 32'h41, 32'h0,        F_BU, 32'h00000000, 1'b0, "b2b_lbu_41"};
      tbl[3] = '{1'b0, 32'h40, 32'h0,        F_X,  32'h0,        1'b1, "b2b_err"};
      tbl[4] = '{1'b0, 32'h42, 32'h0,        F_H,  32'hFFFFA5A5, 1'b0, "b2b_lh_42"};
      foreach (tbl[i]) begin
         push_exp(tbl[i], WS0);
         run_txn(0, tbl[i], rd, er, lat, ra);
         e = sb.pop_front();
         checks++; if (rd !== e.rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", e.name, rd, e.rdata); end
         checks++; if (er !== e.err) begin failures++; $display("FAIL %s err got=%b exp=%b", e.name, er, e.err); end
         checks++; if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat); end
         checks++; if (ra !== 1'b1) begin failures++; $display("FAIL %s ready_after_handshake got=%b exp=1", e.name, ra); end
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_errors();
      test_resp_hold();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
